// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_engine
// Description : Serial transmitter behind the UART_TX memory-mapped register.
//               Bytes written by the CPU are buffered in a small FIFO and
//               shifted out as 8N1 frames, LSB first. A status word lets
//               software poll FIFO occupancy and overflow before writing.
// Ports       :
//   clk      in   1   system clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   wr_en    in   1   single-cycle write strobe from the address decoder
//   wr_data  in   16  CPU data; [7:0] byte, [15] control-write flag
//   tx       out  1   serial line, idle high
//   status   out  16  {8'h00, count[3:0], ovf, empty, full, busy}
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  output logic        tx,
  output logic [15:0] status
);

  localparam int                 c_DEPTH    = 1 << FIFO_AW;
  localparam int                 c_BW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_BW-1:0]    c_BAUD_MAX = c_BW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   c_FULL_CNT = (FIFO_AW + 1)'(c_DEPTH);

  generate
    if (CLKS_PER_BIT < 2 || FIFO_AW < 1 || FIFO_AW > 3) begin : g_bad_params
      $error("uart_tx_engine: CLKS_PER_BIT must be >= 2 and FIFO_AW in 1..3");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  // FIFO storage and bookkeeping
  logic [7:0]         r_mem [c_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic [FIFO_AW:0]   w_count_next;
  logic               r_ovf;

  // Shifter
  logic [c_BW-1:0]    r_baud;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_tx;

  // Registered status flags
  logic               r_busy;
  logic               r_empty;
  logic               r_full;

  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic               w_baud_done;
  logic               w_pop;
  logic               w_tx_next;
  logic               w_push_req;
  logic               w_ctrl_wr;
  logic               w_push;
  logic               w_drop;
  logic               w_unused_bits;

  assign w_fifo_empty  = (r_count == '0);
  assign w_fifo_full   = (r_count == c_FULL_CNT);
  assign w_baud_done   = (r_baud == c_BAUD_MAX);

  assign w_push_req    = wr_en & ~wr_data[15];
  assign w_ctrl_wr     = wr_en &  wr_data[15];
  // A full FIFO still accepts a byte when a pop frees a slot on the same edge.
  assign w_push        = w_push_req & (~w_fifo_full | w_pop);
  assign w_drop        = w_push_req & w_fifo_full & ~w_pop;
  assign w_unused_bits = ^wr_data[14:8];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state, pop request and next line level
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_tx_next    = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        w_tx_next = 1'b0;
        if (w_baud_done) begin
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        w_tx_next = r_shift[0];
        if (w_baud_done && (r_bit_idx == 3'd7)) begin
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        w_tx_next = 1'b1;
        if (w_baud_done) begin
          // Chaining straight into the next start bit keeps frames gap-free.
          if (!w_fifo_empty) begin
            w_pop        = 1'b1;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO count
  // --------------------------------------------------------------------------
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Storage has no reset; only pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_next;
      if (w_ctrl_wr) begin
        r_ovf <= 1'b0;
      end else if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Shifter datapath. The line register follows the state by one cycle, so
  // the start bit appears two edges after the write that fills an idle FIFO.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud    <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_tx      <= 1'b1;
    end else begin
      // Baud counter restarts on every state entry and holds at zero in IDLE.
      if ((r_state == S_IDLE) || (w_state_next != r_state) || w_baud_done) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + 1'b1;
      end

      if ((w_state_next == S_DATA) && (r_state != S_DATA)) begin
        r_bit_idx <= 3'd0;
      end else if ((r_state == S_DATA) && w_baud_done) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end

      if (w_pop) begin
        r_shift <= r_mem[r_rd_ptr];
      end else if ((r_state == S_DATA) && w_baud_done) begin
        r_shift <= {1'b0, r_shift[7:1]};
      end

      r_tx <= w_tx_next;
    end
  end

  // --------------------------------------------------------------------------
  // Status flags, computed from next-state values so they change together
  // with the count and overflow registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_busy  <= (w_state_next != S_IDLE);
      r_empty <= (w_count_next == '0);
      r_full  <= (w_count_next == c_FULL_CNT);
    end
  end

  assign tx     = r_tx;
  assign status = {8'h00, 4'(r_count), r_ovf, r_empty, r_full, r_busy};

endmodule
`default_nettype wire
